// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Instruction memory with a serial big-endian byte loader that holds
//            the core in reset until a program is loaded.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_end,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [31:0]       pc_data,
  output logic [31:0]       instr,
  output logic              cpu_reset,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] c_one = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_buf;
  logic [31:0]       w_packed;
  logic [ADDR_W:0]   r_word_count;
  logic              r_err;
  logic              w_full;
  logic              w_accept;
  logic              w_write;
  logic              w_start;
  logic [31:0]       r_mem [0:DEPTH-1];

  assign w_full = r_word_count[ADDR_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    cpu_reset  = 1'b1;
    load_done  = 1'b0;
    case (r_state)
      S_IDLE: if (load_start) w_next = S_LOAD;
      S_LOAD: begin
        byte_ready = !w_full;
        if (load_end) w_next = S_DONE;
      end
      S_DONE: begin
        load_done = 1'b1;
        w_next    = S_RUN;
      end
      S_RUN: begin
        cpu_reset = 1'b0;
        if (load_start) w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_start  = load_start && ((r_state == S_IDLE) || (r_state == S_RUN));
  assign w_accept = byte_ready && byte_valid;

  // Unfilled low bytes of r_buf stay zero, which gives the padding for free.
  always_comb begin
    w_packed = r_buf;
    if (w_accept) begin
      case (r_byte_cnt)
        2'd0:    w_packed[31:24] = byte_in;
        2'd1:    w_packed[23:16] = byte_in;
        2'd2:    w_packed[15:8]  = byte_in;
        default: w_packed[7:0]   = byte_in;
      endcase
    end
  end

  assign w_write = (r_state == S_LOAD) &&
                   ((w_accept && (r_byte_cnt == 2'd3)) ||
                    (load_end && (w_accept || (r_byte_cnt != 2'd0))));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word_count <= '0;
      r_byte_cnt   <= 2'd0;
      r_buf        <= '0;
    end else if (w_start) begin
      r_word_count <= '0;
      r_byte_cnt   <= 2'd0;
      r_buf        <= '0;
    end else if (w_write) begin
      r_word_count <= r_word_count + c_one;
      r_byte_cnt   <= 2'd0;
      r_buf        <= '0;
    end else if (w_accept) begin
      r_byte_cnt   <= r_byte_cnt + 2'd1;
      r_buf        <= w_packed;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          r_err <= 1'b0;
    else if (w_start)                                    r_err <= 1'b0;
    else if ((r_state == S_LOAD) && w_full && byte_valid) r_err <= 1'b1;
  end

  // Array is deliberately unreset so contents survive across loads.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_word_count[ADDR_W-1:0]] <= w_packed;
  end

  always_comb begin
    instr = '0;
    if ((r_state == S_RUN) && (pc_data < {{(31-ADDR_W){1'b0}}, r_word_count}))
      instr = r_mem[pc_data[ADDR_W-1:0]];
  end

  assign word_count   = r_word_count;
  assign err_overflow = r_err;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Randomised self-checking bench for imem_loader against a
//            byte-queue / word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              load_start = 1'b0;
  logic              load_end = 1'b0;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic [31:0]       pc_data = 32'h0;
  logic [31:0]       instr;
  logic              cpu_reset;
  logic              load_done;
  logic [ADDR_W:0]   word_count;
  logic              err_overflow;

  int total = 0;
  int bad   = 0;

  logic [7:0]  q[$];
  logic [7:0]  acc[$];
  logic [31:0] model_mem [0:DEPTH-1];
  int          model_wc;
  bit          exp_err;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_end(load_end),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .pc_data(pc_data), .instr(instr), .cpu_reset(cpu_reset),
    .load_done(load_done), .word_count(word_count), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Offers every byte of q; each valid offer consumes a byte whether or not
  // it is accepted. Starts and ends 1 time unit after a clock edge.
  task automatic run_load(input int valid_pct, input bit end_on_last, input bit poke_start);
    int idx = 0;
    int cyc = 0;
    bit v;
    acc.delete();
    exp_err = 1'b0;
    while (idx < q.size()) begin
      if (cyc++ > 2000) begin
        total++; bad++;
        $display("FAIL load_budget: got %0d offered of %0d bytes", idx, q.size());
        break;
      end
      v          = ($urandom_range(99) < valid_pct);
      byte_valid = v;
      byte_in    = v ? q[idx] : 8'($urandom);
      load_start = poke_start ? 1'($urandom_range(1)) : 1'b0;
      load_end   = end_on_last && v && (idx == q.size() - 1);
      pc_data    = $urandom_range(DEPTH - 1);
      total++;
      if (byte_ready !== (acc.size() < 4 * DEPTH)) begin
        bad++;
        $display("FAIL load_ready: got %b want %b (accepted=%0d)", byte_ready, acc.size() < 4 * DEPTH, acc.size());
      end
      total++;
      if (instr !== 32'h0 || cpu_reset !== 1'b1) begin
        bad++;
        $display("FAIL load_fetch_hold: instr=%h cpu_reset=%b want 0/1", instr, cpu_reset);
      end
      tick();
      if (v) begin
        if (acc.size() < 4 * DEPTH) acc.push_back(q[idx]);
        else exp_err = 1'b1;
        idx++;
      end
    end
    byte_valid = 1'b0;
    load_start = 1'b0;
    if (!end_on_last || q.size() == 0) begin
      load_end = 1'b1;
      tick();
    end
    load_end = 1'b0;
  endtask

  // Called just after the load_end edge: checks DONE, then RUN and fetches.
  task automatic check_done(input string name);
    logic [31:0] exp;
    logic [31:0] w;
    model_wc = (acc.size() + 3) / 4;
    for (int i = 0; i < model_wc; i++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4 * i + b < acc.size()) w[31 - 8*b -: 8] = acc[4*i + b];
      model_mem[i] = w;
    end
    total++;
    if (load_done !== 1'b1 || cpu_reset !== 1'b1 || byte_ready !== 1'b0 || instr !== 32'h0) begin
      bad++;
      $display("FAIL %s_done_state: done=%b cpu_reset=%b ready=%b instr=%h want 1/1/0/0", name, load_done, cpu_reset, byte_ready, instr);
    end
    total++;
    if (word_count !== (ADDR_W+1)'(model_wc) || err_overflow !== exp_err) begin
      bad++;
      $display("FAIL %s_count: word_count=%0d err=%b want %0d/%b", name, word_count, err_overflow, model_wc, exp_err);
    end
    tick();
    total++;
    if (load_done !== 1'b0 || cpu_reset !== 1'b0 || err_overflow !== exp_err) begin
      bad++;
      $display("FAIL %s_run_state: done=%b cpu_reset=%b err=%b want 0/0/%b", name, load_done, cpu_reset, err_overflow, exp_err);
    end
    for (int pc = 0; pc < DEPTH + 3; pc++) begin
      pc_data = (pc == DEPTH + 2) ? 32'hFFFF_FFFF : 32'(pc);
      #1;
      exp = (pc < model_wc) ? model_mem[pc] : 32'h0;
      total++;
      if (instr !== exp) begin
        bad++;
        $display("FAIL %s_fetch: pc=%h instr=%h want %h", name, pc_data, instr, exp);
      end
    end
    tick();
    total++;
    if (load_done !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_pulse: load_done=%b want 0", name, load_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    total++;
    if (cpu_reset !== 1'b1 || byte_ready !== 1'b0 || load_done !== 1'b0 ||
        word_count !== '0 || err_overflow !== 1'b0 || instr !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: cpu_reset=%b ready=%b done=%b wc=%0d err=%b instr=%h", cpu_reset, byte_ready, load_done, word_count, err_overflow, instr);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    byte_valid = 1'b1;
    byte_in = 8'h55;
    tick();
    total++;
    if (byte_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_ready: got %b want 0", byte_ready);
    end
    byte_valid = 1'b0;
    start_load();
    byte_valid = 1'b1;
    byte_in = 8'hDE; tick();
    byte_in = 8'hAD; tick();
    byte_valid = 1'b0;
    reset = 1'b0;
    #2;
    total++;
    if (cpu_reset !== 1'b1 || byte_ready !== 1'b0 || word_count !== '0) begin
      bad++;
      $display("FAIL reset_mid_load: cpu_reset=%b ready=%b wc=%0d want 1/0/0", cpu_reset, byte_ready, word_count);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    start_load();
    q = '{8'h00, 8'h00, 8'h00, 8'h20};
    run_load(100, 1'b0, 1'b0);
    check_done("reset_reload");
  endtask

  task automatic test_basic();
    start_load();
    q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    run_load(100, 1'b0, 1'b0);
    check_done("basic");
  endtask

  task automatic test_partial_end();
    start_load();
    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load(100, 1'b1, 1'b0);
    check_done("partial_end");
  endtask

  task automatic test_stall();
    for (int it = 0; it < 8; it++) begin
      start_load();
      q.delete();
      for (int i = 0; i < $urandom_range(14, 1); i++) q.push_back(8'($urandom));
      run_load(50, 1'($urandom_range(1)), 1'b1);
      check_done("stall");
    end
  endtask

  task automatic test_overflow();
    start_load();
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    run_load(100, 1'b1, 1'b0);
    check_done("overflow");
  endtask

  task automatic test_reload_from_run();
    pc_data = 32'h0;
    start_load();
    total++;
    if (cpu_reset !== 1'b1 || instr !== 32'h0 || err_overflow !== 1'b0 || word_count !== '0) begin
      bad++;
      $display("FAIL reload_edge: cpu_reset=%b instr=%h err=%b wc=%0d want 1/0/0/0", cpu_reset, instr, err_overflow, word_count);
    end
    q = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_load(100, 1'b0, 1'b0);
    check_done("reload");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_end();
    test_stall();
    test_overflow();
    test_reload_from_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Instruction memory with a serial byte loader, sitting directly upstream of the single-cycle `cpu`. Ahead of execution it accepts a program as a byte stream over a valid/ready handshake, packs bytes into 32-bit words, and holds the core in reset. Once the load completes it releases the core and serves `instr` combinationally from the core's word-addressed `pc_data`, giving a same-cycle instruction fetch.

## Interface
- `ADDR_W`, default 8: word-address width. Depth = 2^ADDR_W words.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  single-cycle request to begin a program load.
- `load_end`  in  1  single-cycle marker that the stream is finished.
- `byte_in`  in  8  program byte, big-endian within each word.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader can accept a byte.
- `pc_data`  in  32  word address from the core (PC increments by 1).
- `instr`  out  32  instruction to the core.
- `cpu_reset`  out  1  active-high hold to the core's `reset`.
- `load_done`  out  1  one-cycle pulse when a load completes.
- `word_count`  out  ADDR_W+1  number of words written by the last or current load.
- `err_overflow`  out  1  sticky flag: a byte was offered while memory was full.

## Operation
- States: IDLE, LOAD, DONE, RUN.
- IDLE: `cpu_reset`=1, `byte_ready`=0. `load_start` moves the block to LOAD and clears `word_count`, the byte counter and `err_overflow`.
- LOAD:
  - `byte_ready` = 1 while `word_count` < 2^ADDR_W.
  - A byte is accepted when `byte_valid` and `byte_ready` are both high. The 1st byte goes to [31:24], the 2nd to [23:16], the 3rd to [15:8] and the 4th to [7:0].
  - On the 4th byte, the assembled word is written to mem[`word_count`], `word_count` increments, and the byte counter returns to 0.
  - `load_start` is ignored while in LOAD.
- `load_end` in LOAD moves the block to DONE.
  - If a byte is accepted on the same cycle, that byte is included first.
  - If 1–3 bytes are pending, the partial word is written zero-padded in the low bytes and `word_count` increments.
  - If 0 bytes are pending, nothing is written.
- Full memory: when `word_count` = 2^ADDR_W, `byte_ready`=0. Any `byte_valid` in that state sets `err_overflow`, and the byte is dropped. The load still ends only on `load_end`.
- DONE lasts one cycle: `load_done`=1 and `cpu_reset`=1. The next state is RUN.
- RUN:
  - `cpu_reset`=0.
  - `instr` = mem[`pc_data`[ADDR_W-1:0]] when `pc_data` < `word_count`; otherwise `instr` = 0 (the `sll` nop).
  - `load_start` returns the block to LOAD; `cpu_reset` goes to 1 from that edge.
- `instr` = 0 in IDLE, LOAD and DONE.
- Memory array contents are not reset and persist across loads. Only words below the new `word_count` are fetchable.
- Reset (async, mid-operation included):
  - State → IDLE. `byte_ready`=0, `cpu_reset`=1, `load_done`=0, `word_count`=0, `err_overflow`=0, byte counter=0.
  - Any partial word is discarded.

## Timing
- `byte_ready`, `cpu_reset` and `load_done` decode combinationally from registered state and `word_count`. They do not depend on `byte_valid`.
- Read path `pc_data` → `instr` is combinational, so the core sees its instruction in the same cycle.
- Edges, with `load_end` sampled at edge N:
  - Edge N: final word written, state = DONE.
  - Between N and N+1: `load_done` high.
  - Edge N+1: state = RUN; `cpu_reset` falls after N+1, so the core's first fetch cycle follows N+1.
- `load_start` sampled at edge M in RUN: `cpu_reset`=1 and `instr`=0 from edge M.
- Throughput: one byte per cycle; a full word takes 4 accepted bytes.

## Test plan
- **Reset:** assert `reset`=0 mid-LOAD after 2 bytes → `cpu_reset`=1, `byte_ready`=0, `word_count`=0. Then reload {00,00,00,20} → mem[0] = 0x00000020.
- **Basic load:** `load_start`, then 8 bytes {20,08,00,05, 01,09,50,20} with `byte_valid` held, then `load_end` → `word_count`=2 and one `load_done` pulse. `cpu_reset` falls one cycle after DONE. `pc_data`=0 gives `instr`=0x20080005, `pc_data`=1 gives 0x01095020, `pc_data`=2 gives 0.
- **Partial word and simultaneous end:** 5 bytes {AA,BB,CC,DD,EE}, with `load_end` on the same cycle as the 5th byte → mem[1] = 0xEE000000 and `word_count`=2.
- **Stalled handshake:** toggle `byte_valid` randomly → only cycles with both `byte_valid` and `byte_ready` high advance; packed words match the reference byte order.
- **Overflow:** with ADDR_W=2, offer 20 bytes → `byte_ready` drops after 16 bytes, `err_overflow`=1, `word_count`=4, and the remaining bytes are dropped.
- **Reload from RUN:** pulse `load_start` while running → `cpu_reset`=1 and `instr`=0 from that edge. Load 1 word → `pc_data`=1 returns 0 even though the old mem[1] still holds data.
